featuremap_stream_source: RTL and testbench

Producer end of the layer feature-map stream. Reads a stored feature map (16 fp32 channels packed per 512-bit word) from a synchronous-read buffer RAM and emits it pixel by pixel in raster order on the `data_out`/`valid_out` stream that feeds a layer's per-channel Conv2D3x3 array. Sits between the inter-layer feature-map buffer and the next layer's featuremap modules, and adds `ready_in` backpressure so downstream stalls never drop pixels.

---
 rtl/fm_stream_pkg.sv | 25 ++
 rtl/fm_skid_fifo.sv | 69 ++++++
 rtl/featuremap_stream_source.sv | 187 ++++++++++++++++++
 tb/tb_featuremap_stream_source.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_stream_pkg.sv
// Shared definitions for the feature-map stream blocks.
//   FP_WIDTH / CH_PER_WORD : fp32 channels packed per stream word
//   DEFAULT_*              : default geometry of the layer feature map
//   fm_state_e             : stream source FSM states
//   frame_dim()            : streamed frame edge length, with or without a zero border
package fm_stream_pkg;

    localparam int unsigned FP_WIDTH           = 32;
    localparam int unsigned CH_PER_WORD        = 16;
    localparam int unsigned DEFAULT_DATA_WIDTH = FP_WIDTH * CH_PER_WORD;
    localparam int unsigned DEFAULT_IMG_SIZE   = 208;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2
    } fm_state_e;

    // A one-pixel zero border adds one row/column on each side.
    function automatic int unsigned frame_dim(input int unsigned img_size, input bit pad);
        return pad ? img_size + 2 : img_size;
    endfunction

endpackage

// File: rtl/fm_skid_fifo.sv
// Two-entry registered FIFO used as the output skid buffer of the stream source.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   push_i/push_data_i: write one word (ignored when full unless a pop frees a slot)
//   pop_i             : drop the head word (ignored when empty)
//   head_o            : current head word (entry 0)
//   count_o           : occupancy 0..2
//   full_o, empty_o   : occupancy flags
module fm_skid_fifo
    import fm_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]       count_q, count_d;
    logic [1:0]       fill_level;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;

        // Pop shifts entry 1 forward; the push then lands in the first free slot.
        if (do_pop) begin
            ent0_d = ent1_q;
        end
        fill_level = count_q - {1'b0, do_pop};
        if (do_push) begin
            if (fill_level == 2'd0) begin
                ent0_d = push_data_i;
            end else begin
                ent1_d = push_data_i;
            end
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = ent0_q;
    assign count_o = count_q;
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/featuremap_stream_source.sv
// Feature-map stream source: reads a stored feature map from a synchronous-read RAM and
// emits it pixel by pixel in raster order with ready/valid backpressure.
//   Clk, Rst (async, active-low)
//   start, base_addr         : one-cycle frame request; base_addr is the RAM address of (0,0)
//   mem_rd_en, mem_addr      : RAM read request; mem_rd_data returns one cycle later
//   data_out, valid_out      : stream word (channel k at bits [32k+31:32k]) and its valid
//   ready_in                 : downstream accept
//   busy, done               : frame in progress; one-cycle pulse on the last transfer
// Build option FM_ZERO_PAD_EN: stream (IMG_SIZE+2)^2 pixels with a one-pixel zero border.
module featuremap_stream_source
    import fm_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned IMG_SIZE   = DEFAULT_IMG_SIZE,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  busy,
    output logic                  done
);

`ifdef FM_ZERO_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    localparam int unsigned FrameDim = frame_dim(IMG_SIZE, PadEn);
    localparam int unsigned FramePix = FrameDim * FrameDim;
    localparam int unsigned PosW     = (FrameDim > 1) ? $clog2(FrameDim) : 1;
    localparam int unsigned CntW     = $clog2(FramePix + 1);

    localparam logic [PosW-1:0] LastPos = PosW'(FrameDim - 1);
    localparam logic [CntW-1:0] LastPix = CntW'(FramePix - 1);

    fm_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PosW-1:0]       row_q, row_d;
    logic [PosW-1:0]       col_q, col_d;
    logic [CntW-1:0]       out_cnt_q, out_cnt_d;
    logic                  inflight_q, inflight_d;

    logic                  issue;
    logic                  pop;
    logic [2:0]            in_use;
    logic                  credit_ok;
    logic [DATA_WIDTH-1:0] push_data;
    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  unused_fifo_full;

`ifdef FM_ZERO_PAD_EN
    logic                  slot_border;
    logic                  pad_q, pad_d;
`endif

    always_comb begin
        pop       = valid_out && ready_in;
        // Words already buffered plus the read returning next edge, less this cycle's pop.
        in_use    = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        credit_ok = (in_use < 3'd2);

        state_d   = state_q;
        addr_d    = addr_q;
        row_d     = row_q;
        col_d     = col_q;
        out_cnt_d = out_cnt_q;
        issue     = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d    = base_addr;
                    row_d     = '0;
                    col_d     = '0;
                    out_cnt_d = '0;
                    state_d   = StStream;
                end
            end
            StStream: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (col_q == LastPos) begin
                        col_d = '0;
                        if (row_q == LastPos) begin
                            row_d   = '0;
                            state_d = StDrain;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                // Waiting for the buffered tail of the frame to transfer.
            end
            default: state_d = StIdle;
        endcase

`ifdef FM_ZERO_PAD_EN
        slot_border = (row_q == '0) || (row_q == LastPos) || (col_q == '0) || (col_q == LastPos);
        mem_rd_en   = issue && !slot_border;
        pad_d       = issue && slot_border;
        push_data   = pad_q ? '0 : mem_rd_data;
`else
        mem_rd_en   = issue;
        push_data   = mem_rd_data;
`endif

        // The address only advances on real reads, so interior pixels stay contiguous.
        if (mem_rd_en) begin
            addr_d = addr_q + 1'b1;
        end
        if (pop) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
        if ((state_q == StDrain) && pop && (out_cnt_q == LastPix)) begin
            done    = 1'b1;
            state_d = StIdle;
        end
    end

    assign inflight_d = issue;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            row_q      <= row_d;
            col_q      <= col_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef FM_ZERO_PAD_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pad_q <= 1'b0;
        end else begin
            pad_q <= pad_d;
        end
    end
`endif

    fm_skid_fifo #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk_i       (Clk),
        .rst_ni      (Rst),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (data_out),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Credit is derived from the exact count, so the full flag carries no extra information.
    assign unused_fifo_full = fifo_full;

    assign mem_addr  = addr_q;
    assign valid_out = !fifo_empty;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_featuremap_stream_source.sv
// Self-checking bench for featuremap_stream_source: a behavioural RAM plus a frame model
// that lists the expected read addresses and pixel words in raster order.
module tb_featuremap_stream_source;

`ifdef FM_ZERO_PAD_EN
    localparam int IMG = 2;
    localparam bit PAD = 1'b1;
`else
    localparam int IMG = 4;
    localparam bit PAD = 1'b0;
`endif
    localparam int DIM = PAD ? IMG + 2 : IMG;
    localparam int PIX = DIM * DIM;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  base_addr = '0;
    logic         mem_rd_en;
    logic [15:0]  mem_addr;
    logic [511:0] mem_rd_data = '0;
    logic [511:0] data_out;
    logic         valid_out;
    logic         ready_in = 1'b1;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned ram_seed = 32'h1234_5678;

    logic [15:0]  exp_addr[$];
    logic [511:0] exp_data[$];
    logic [15:0]  got_addr[$];
    logic [511:0] got_data[$];

    // Results of the last run_frame call.
    int done_cnt, done_cycle, first_valid, max_out;
    bit busy_at_done;

    featuremap_stream_source #(
        .DATA_WIDTH (512),
        .IMG_SIZE   (IMG),
        .ADDR_WIDTH (16)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .start       (start),
        .base_addr   (base_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .busy        (busy),
        .done        (done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [511:0] ram_word(input logic [15:0] a);
        logic [511:0] w;
        for (int k = 0; k < 16; k++) begin
            w[32*k +: 32] = {a, 16'(k)} ^ (ram_seed * 32'(k + 1));
        end
        return w;
    endfunction

    // Synchronous-read RAM: data appears one cycle after the read enable.
    always @(posedge Clk) begin
        if (mem_rd_en) mem_rd_data <= ram_word(mem_addr);
    end

    // Raster-order frame: border slots are zero words with no read; interior pixel (r,c)
    // lives at base + r*IMG + c modulo 2^16.
    task automatic build_expected(input logic [15:0] base);
        int r, c, ir, ic;
        logic [15:0] a;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < PIX; i++) begin
            r = i / DIM;
            c = i % DIM;
            if (PAD && (r == 0 || c == 0 || r == DIM - 1 || c == DIM - 1)) begin
                exp_data.push_back('0);
            end else begin
                ir = PAD ? r - 1 : r;
                ic = PAD ? c - 1 : c;
                a  = base + 16'(ir * IMG + ic);
                exp_addr.push_back(a);
                exp_data.push_back(ram_word(a));
            end
        end
    endtask

    // mode 0: ready high; 1: ready one cycle in three; 2: random ready.
    task automatic run_frame(input logic [15:0] base, input int mode, input bit mid_start);
        int  issued, xfers, last_done_e;
        bit  stall_prev;
        logic [511:0] stall_data;
        got_addr.delete();
        got_data.delete();
        done_cnt = 0; done_cycle = -1; first_valid = -1; max_out = 0; busy_at_done = 0;
        issued = 0; xfers = 0; last_done_e = 0; stall_prev = 0; stall_data = '0;
        @(posedge Clk); #1;
        start = 1'b1;
        base_addr = base;
        ready_in = 1'b1;
        @(posedge Clk); // start sampled on this edge
        for (int e = 0; e < 400; e++) begin
            #1;
            start = mid_start && (e == 6);
            if (start) base_addr = ~base;
            case (mode)
                1:       ready_in = (e % 3 == 0);
                2:       ready_in = 1'($urandom_range(0, 1));
                default: ready_in = 1'b1;
            endcase
            @(negedge Clk);
            if (mem_rd_en) begin got_addr.push_back(mem_addr); issued++; end
            if (valid_out && first_valid < 0) first_valid = e;
            if (stall_prev) begin
                n_checks++;
                if (valid_out !== 1'b1 || data_out !== stall_data) begin
                    n_errors++;
                    $display("FAIL hold_stable e=%0d: valid=%b data[31:0]=%h, need valid=1 data[31:0]=%h",
                             e, valid_out, data_out[31:0], stall_data[31:0]);
                end
            end
            stall_prev = valid_out && !ready_in;
            stall_data = data_out;
            if (valid_out && ready_in) begin got_data.push_back(data_out); xfers++; end
            if (issued - xfers > max_out) max_out = issued - xfers;
            if (done === 1'b1) begin
                done_cnt++;
                done_cycle = e + 1; // done cycle ends at edge k+e+1
                busy_at_done = busy;
                last_done_e = e;
            end
            if (done_cnt > 0 && e >= last_done_e + 4) break;
            @(posedge Clk);
        end
        #1;
        start = 1'b0;
        ready_in = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        n_checks++;
        if (got_addr.size() != exp_addr.size()) begin
            n_errors++;
            $display("FAIL %s read_count: got %0d reads, need %0d", tag, got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            n_checks++;
            if (got_addr[i] !== exp_addr[i]) begin
                n_errors++;
                $display("FAIL %s addr[%0d]: got %h, need %h", tag, i, got_addr[i], exp_addr[i]);
            end
        end
        n_checks++;
        if (got_data.size() != exp_data.size()) begin
            n_errors++;
            $display("FAIL %s pixel_count: got %0d, need %0d", tag, got_data.size(), exp_data.size());
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== exp_data[i]) begin
                n_errors++;
                $display("FAIL %s pixel[%0d]: got %h, need %h", tag, i, got_data[i][63:0], exp_data[i][63:0]);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_errors++;
            $display("FAIL %s done_count: got %0d, need 1", tag, done_cnt);
        end
        n_checks++;
        if (busy_at_done !== 1'b1) begin
            n_errors++;
            $display("FAIL %s busy_at_done: got %b, need 1", tag, busy_at_done);
        end
        n_checks++;
        if (busy !== 1'b0 || valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL %s idle_after: busy=%b valid=%b, need 0 0", tag, busy, valid_out);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if ({mem_rd_en, valid_out, busy, done} !== 4'b0 || mem_addr !== 16'h0 || data_out !== '0) begin
            n_errors++;
            $display("FAIL reset_in: rd=%b valid=%b busy=%b done=%b addr=%h, need all 0",
                     mem_rd_en, valid_out, busy, done, mem_addr);
        end
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        n_checks++;
        if ({mem_rd_en, valid_out, busy, done} !== 4'b0 || mem_addr !== 16'h0 || data_out !== '0) begin
            n_errors++;
            $display("FAIL reset_idle: rd=%b valid=%b busy=%b done=%b addr=%h, need all 0",
                     mem_rd_en, valid_out, busy, done, mem_addr);
        end
    endtask

    task automatic test_stream();
        build_expected(16'h0100);
        run_frame(16'h0100, 0, 1'b0);
        check_frame("stream");
        n_checks++;
        if (first_valid != 2) begin
            n_errors++;
            $display("FAIL first_latency: got %0d, need 2", first_valid);
        end
        n_checks++;
        if (done_cycle != PIX + 2) begin
            n_errors++;
            $display("FAIL done_latency: got %0d, need %0d", done_cycle, PIX + 2);
        end
    endtask

    task automatic test_backpressure();
        ram_seed = $urandom;
        build_expected(16'h0100);
        run_frame(16'h0100, 1, 1'b0);
        check_frame("bp_1in3");
        n_checks++;
        if (max_out > 2) begin
            n_errors++;
            $display("FAIL bp_outstanding: got %0d, need <= 2", max_out);
        end
    endtask

    task automatic test_random_ready();
        logic [15:0] b;
        for (int t = 0; t < 3; t++) begin
            ram_seed = $urandom;
            b = 16'($urandom);
            build_expected(b);
            run_frame(b, 2, 1'b0);
            check_frame("rand_ready");
            n_checks++;
            if (max_out > 2) begin
                n_errors++;
                $display("FAIL rand_outstanding: got %0d, need <= 2", max_out);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] b;
        b = 16'h0000 - 16'(IMG * IMG / 2);
        build_expected(b);
        run_frame(b, 0, 1'b0);
        check_frame("wrap");
    endtask

    task automatic test_mid_start();
        build_expected(16'h0200);
        run_frame(16'h0200, 0, 1'b1);
        check_frame("mid_start");
    endtask

    task automatic test_reset_abort();
        int xfers;
        bit hit;
        xfers = 0;
        hit = 0;
        @(posedge Clk); #1;
        start = 1'b1;
        base_addr = 16'h0300;
        ready_in = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        for (int e = 0; e < 100 && !hit; e++) begin
            @(negedge Clk);
            if (valid_out && ready_in) xfers++;
            if (xfers == 7) hit = 1;
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL abort_reach_pixel7: got %0d transfers, need 7", xfers);
        end
        #2;
        Rst = 1'b0;
        #1;
        n_checks++;
        if ({valid_out, busy, mem_rd_en, done} !== 4'b0 || data_out !== '0) begin
            n_errors++;
            $display("FAIL abort_immediate: valid=%b busy=%b rd=%b done=%b, need all 0",
                     valid_out, busy, mem_rd_en, done);
        end
        @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if ({valid_out, busy, done} !== 3'b0) begin
            n_errors++;
            $display("FAIL abort_held: valid=%b busy=%b done=%b, need 0 0 0", valid_out, busy, done);
        end
        Rst = 1'b1;
        ram_seed = $urandom;
        build_expected(16'h0300);
        run_frame(16'h0300, 0, 1'b0);
        check_frame("after_abort");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random_ready();
        test_wrap();
        test_mid_start();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
